// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and load/store.
// Alternating priority, one access at a time, configurable read latency, registered read data.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_mask,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_mask,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall,
  output logic                  busy
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic               prio;
  logic               g_data;
  logic               g_we;
  logic [CNT_W-1:0]   cnt;
  logic               pick_data_c;

  // Data wins a tie unless it was the last port served.
  assign pick_data_c = d_req & (~if_req | ~prio);

  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      g_data    <= 1'b0;
      g_we      <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mask  <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | d_req) begin
            g_data    <= pick_data_c;
            g_we      <= pick_data_c & d_we;
            prio      <= pick_data_c;
            mem_addr  <= pick_data_c ? d_addr : if_addr;
            mem_wdata <= pick_data_c ? d_wdata : '0;
            mem_mask  <= (pick_data_c & d_we) ? d_mask : '0;
            mem_en    <= 1'b1;
            mem_we    <= pick_data_c & d_we;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (g_we) begin
            d_ack <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= CNT_W'(MEM_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (g_data) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Mandatory IDLE follows so a req still held during ack is not re-granted.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, stall, busy;
  logic [7:0]  if_addr, d_addr, mem_addr;
  logic [31:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0]  d_mask, mem_mask;

  logic        l3_if_req, l3_if_ack, l3_d_req, l3_d_we, l3_d_ack, l3_mem_en, l3_mem_we, l3_stall, l3_busy;
  logic [7:0]  l3_if_addr, l3_d_addr, l3_mem_addr;
  logic [31:0] l3_if_rdata, l3_d_wdata, l3_d_rdata, l3_mem_wdata, l3_mem_rdata;
  logic [3:0]  l3_d_mask, l3_mem_mask;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata), .stall(stall), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT3)) u_lat3 (
    .clk(clk), .rst(rst),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_rdata(l3_if_rdata), .if_ack(l3_if_ack),
    .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata), .d_mask(l3_d_mask),
    .d_rdata(l3_d_rdata), .d_ack(l3_d_ack),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_mask(l3_mem_mask), .mem_rdata(l3_mem_rdata), .stall(l3_stall), .busy(l3_busy)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    case (a)
      8'h10:   return 32'h00500093;
      8'h3F:   return 32'hFFFFFF80;
      default: return {8'hC0, a, 8'h5A, a};
    endcase
  endfunction

  // Memory device for the main instance: read data appears only in its latency slot.
  logic [31:0] dev_mem [256];
  bit          dev_init = 1'b0;
  logic        dv_pipe [LAT];
  logic [31:0] dd_pipe [LAT];
  always @(posedge clk) begin
    if (!dev_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] = init_word(8'(i));
      dev_init = 1'b1;
    end
    for (int i = LAT - 1; i > 0; i--) begin
      dv_pipe[i] <= dv_pipe[i-1];
      dd_pipe[i] <= dd_pipe[i-1];
    end
    dv_pipe[0] <= mem_en && !mem_we;
    dd_pipe[0] <= dev_mem[mem_addr];
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) dev_mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
  end
  assign mem_rdata = (dv_pipe[LAT-1] === 1'b1) ? dd_pipe[LAT-1] : 32'hBAD0BAD0;

  logic        lv_pipe [LAT3];
  logic [31:0] ld_pipe [LAT3];
  always @(posedge clk) begin
    for (int i = LAT3 - 1; i > 0; i--) begin
      lv_pipe[i] <= lv_pipe[i-1];
      ld_pipe[i] <= ld_pipe[i-1];
    end
    lv_pipe[0] <= l3_mem_en && !l3_mem_we;
    ld_pipe[0] <= init_word(l3_mem_addr);
  end
  assign l3_mem_rdata = (lv_pipe[LAT3-1] === 1'b1) ? ld_pipe[LAT3-1] : 32'hBAD0BAD0;

  // Reference model: each grant is scheduled as a whole transaction on a cycle timeline.
  int          k = 0;
  int          m_free = 0;
  int          t_issue = 0;
  int          t_done = 0;
  bit          t_valid = 1'b0;
  bit          t_data = 1'b0;
  bit          t_we = 1'b0;
  bit          last_data = 1'b0;
  bit          ref_init = 1'b0;
  logic [7:0]  t_addr;
  logic [31:0] t_wdata, t_rdata;
  logic [3:0]  t_mask;
  logic [31:0] e_if_rdata = 32'h0;
  logic [31:0] e_d_rdata = 32'h0;
  logic [31:0] ref_mem [256];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (!ref_init) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        ref_init = 1'b1;
      end
      t_valid    = 1'b0;
      last_data  = 1'b0;
      m_free     = k;
      e_if_rdata = 32'h0;
      e_d_rdata  = 32'h0;
    end else begin
      if (k >= m_free && (if_req || d_req)) begin
        t_data    = d_req && (!if_req || !last_data);
        last_data = t_data;
        t_valid   = 1'b1;
        t_we      = t_data && d_we;
        t_addr    = t_data ? d_addr : if_addr;
        t_wdata   = d_wdata;
        t_mask    = d_mask;
        t_issue   = k + 1;
        t_done    = t_issue + (t_we ? 1 : 1 + LAT);
        m_free    = t_done + 1;
        if (t_we) begin
          for (int b = 0; b < 4; b++)
            if (t_mask[b]) ref_mem[t_addr][8*b +: 8] = t_wdata[8*b +: 8];
        end else begin
          t_rdata = ref_mem[t_addr];
        end
      end
      k = k + 1;
      if (t_valid && !t_we && k == t_done) begin
        if (t_data) e_d_rdata = t_rdata;
        else        e_if_rdata = t_rdata;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  // Advance to the next falling edge and check every main-instance output against the model.
  task automatic tick();
    bit inw, e_en, e_ifa, e_da;
    @(negedge clk);
    inw   = t_valid && k >= t_issue && k <= t_done;
    e_en  = t_valid && k == t_issue;
    e_ifa = t_valid && !t_data && k == t_done;
    e_da  = t_valid && t_data && k == t_done;
    chk1("busy", busy, inw);
    chk1("mem_en", mem_en, e_en);
    chk1("mem_we", mem_we, e_en && t_we);
    chk1("if_ack", if_ack, e_ifa);
    chk1("d_ack", d_ack, e_da);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk1("stall", stall, (if_req && !e_ifa) || (d_req && !e_da));
    if (inw) begin
      chk("mem_addr", 32'(mem_addr), 32'(t_addr));
      chk("mem_mask", 32'(mem_mask), t_we ? 32'(t_mask) : 32'h0);
      if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
    end
  endtask

  int         ng;
  logic [3:0] got;

  initial begin
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_mask = '0;
    l3_if_req = 0; l3_if_addr = '0; l3_d_req = 0; l3_d_we = 0; l3_d_addr = '0;
    l3_d_wdata = '0; l3_d_mask = '0;

    repeat (2) tick();
    chk1("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    rst = 1'b1;

    // Abandon a read in WAIT with an asynchronous reset.
    if_req = 1; if_addr = 8'h05;
    tick();
    chk1("abort_issue_en", mem_en, 1'b1);
    tick();
    chk1("abort_wait_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk1("abort_mem_en", mem_en, 1'b0);
    chk1("abort_if_ack", if_ack, 1'b0);
    chk1("abort_d_ack", d_ack, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    if_addr = 8'h04;
    repeat (2) tick();
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk1("release_idle_en", mem_en, 1'b0);
    tick();
    chk1("release_mem_en", mem_en, 1'b1);
    chk("release_mem_addr", 32'(mem_addr), 32'h04);
    repeat (2) tick();
    chk1("release_if_ack", if_ack, 1'b1);
    chk("release_if_rdata", if_rdata, 32'hC0045A04);
    if_req = 0;
    tick();

    // Fetch read from 0x10.
    if_req = 1; if_addr = 8'h10;
    #1 chk1("fetch_stall_T", stall, 1'b1);
    tick();
    chk1("fetch_en_T1", mem_en, 1'b1);
    chk("fetch_addr_T1", 32'(mem_addr), 32'h10);
    tick();
    chk1("fetch_stall_T2", stall, 1'b1);
    tick();
    chk1("fetch_ack_T3", if_ack, 1'b1);
    chk("fetch_rdata_T3", if_rdata, 32'h00500093);
    chk1("fetch_stall_T3", stall, 1'b0);
    if_req = 0;
    tick();

    // Masked store to 0x20.
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 32'hDEADBEEF; d_mask = 4'b0011;
    tick();
    chk1("store_en", mem_en, 1'b1);
    chk1("store_we", mem_we, 1'b1);
    chk("store_addr", 32'(mem_addr), 32'h20);
    chk("store_wdata", mem_wdata, 32'hDEADBEEF);
    chk("store_mask", 32'(mem_mask), 32'h3);
    tick();
    chk1("store_d_ack", d_ack, 1'b1);
    chk1("store_if_ack", if_ack, 1'b0);
    d_req = 0; d_we = 0; d_mask = '0;
    tick();

    // Read back the partially written word.
    if_req = 1; if_addr = 8'h20;
    repeat (3) tick();
    chk("readback_rdata", if_rdata, 32'hC020BEEF);
    if_req = 0;
    tick();

    // Contention: both held, expect data, fetch, data, fetch.
    if_addr = 8'h11; d_addr = 8'h21; d_we = 0; if_req = 1; d_req = 1;
    ng = 0; got = '0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      tick();
      if (if_ack || d_ack) begin
        chk1("contention_done_en", mem_en, 1'b0);
        if (d_ack) chk("contention_d_rdata", d_rdata, 32'hC0215A21);
        if (if_ack) chk("contention_if_rdata", if_rdata, 32'hC0115A11);
        got[ng] = d_ack;
        ng++;
      end
    end
    chk("contention_grants", 32'(ng), 32'd4);
    chk("contention_order", 32'(got), 32'h5);
    if_req = 0; d_req = 0;
    tick();
    chk1("contention_idle_en", mem_en, 1'b0);

    // MEM_LAT=3 load from 0x3F on the second instance.
    l3_d_req = 1; l3_d_we = 0; l3_d_addr = 8'h3F;
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk1("lat3_mem_en", l3_mem_en, j == 1);
      chk("lat3_mem_addr", 32'(l3_mem_addr), 32'h3F);
      chk("lat3_mem_mask", 32'(l3_mem_mask), 32'h0);
      chk1("lat3_d_ack", l3_d_ack, j == 5);
      chk1("lat3_if_ack", l3_if_ack, 1'b0);
      chk("lat3_d_rdata", l3_d_rdata, (j == 5) ? 32'hFFFFFF80 : 32'h0);
    end
    l3_d_req = 0;
    tick();
    chk1("lat3_busy", l3_busy, 1'b0);
    chk1("lat3_stall", l3_stall, 1'b0);
    chk("lat3_if_rdata", l3_if_rdata, 32'h0);
    chk("lat3_mem_wdata", l3_mem_wdata, 32'h0);

    // Load whose request drops during ISSUE still completes.
    d_req = 1; d_we = 0; d_addr = 8'h30;
    tick();
    chk1("drop_issue_en", mem_en, 1'b1);
    d_req = 0;
    tick();
    tick();
    chk1("drop_d_ack", d_ack, 1'b1);
    chk("drop_d_rdata", d_rdata, 32'hC0305A30);
    tick();
    chk1("drop_busy", busy, 1'b0);
    chk1("drop_d_ack_gone", d_ack, 1'b0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
